rgb_pwm_driver: RTL

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

---
 rtl/rgb_pwm_driver_pkg.sv | 25 ++
 rtl/rgb_pwm_driver_if.sv | 22 ++
 rtl/rgb_pwm_driver_pwm_channel.sv | 11 +
 rtl/rgb_pwm_driver.sv | 96 +++++++++
 4 files changed

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants, field layout and state encoding for the RGB PWM driver.
package rgb_pwm_driver_pkg;

    localparam logic [7:0] PWM_LAST_STEP = 8'd254;
    localparam int         DUTY_W        = 8;

    localparam int RED_LSB = 16;
    localparam int GRN_LSB = 8;
    localparam int BLU_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Channel index 0/1/2 maps to blue/green/red so led vector bits line up with rgb.
    function automatic int chan_lsb(input int ch);
        case (ch)
            0:       return BLU_LSB;
            1:       return GRN_LSB;
            default: return RED_LSB;
        endcase
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour/enable inputs and LED/status outputs of the RGB PWM driver.
interface rgb_pwm_driver_if;

    logic        enable;
    logic [23:0] rgb;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        frame_start;
    logic [23:0] duty_active;

    modport master (
        output enable, rgb,
        input  led_r, led_g, led_b, frame_start, duty_active
    );

    modport slave (
        input  enable, rgb,
        output led_r, led_g, led_b, frame_start, duty_active
    );

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM comparator: output high while the step counter is below the duty value.
module pwm_channel (
    input  logic [7:0] duty,
    input  logic [7:0] step,
    input  logic       run,
    output logic       pwm
);

    assign pwm = run && (step < duty);

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver with per-period shadowed duty and a configurable step prescaler.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    rgb_pwm_driver_if.slave  bus
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    step_q, step_d;
    logic [23:0]   shadow_q, shadow_d;

    logic       tick;
    logic       period_end;
    logic       run;
    logic       frame_start;
    logic [2:0] led;

    assign tick       = (presc_q == PRESC_LAST);
    assign period_end = tick && (step_q == PWM_LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            step_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        step_d   = step_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                presc_d  = '0;
                step_d   = '0;
                shadow_d = '0;
                if (bus.enable) begin
                    shadow_d = bus.rgb;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (period_end) begin
                    // enable is only honoured here, so a period always runs to completion
                    step_d = '0;
                    if (bus.enable) begin
                        shadow_d = bus.rgb;
                    end else begin
                        shadow_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (tick) begin
                    step_d = step_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        run         = (state_q == ST_RUN);
        frame_start = run && (step_q == 8'd0) && (presc_q == '0);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        pwm_channel u_chan (
            .duty (shadow_q[chan_lsb(gi) +: DUTY_W]),
            .step (step_q),
            .run  (run),
            .pwm  (led[gi])
        );
    end

    assign bus.led_r       = led[2];
    assign bus.led_g       = led[1];
    assign bus.led_b       = led[0];
    assign bus.frame_start = frame_start;
    assign bus.duty_active = shadow_q;

endmodule
